countdown_display_reader: RTL

- Consumer end of the game countdown timer.
- On each one-second strobe, samples the 32-bit remaining-seconds count and converts it sequentially into four BCD digits for an MM:SS display.
- Converts without hardware dividers; also flags timeout to the game FSM.
- Sits between the second counter and the HUD / seven-segment driver.

---
 rtl/countdown_display_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/countdown_display_reader.sv
// Countdown reader: samples remaining seconds on each strobe and converts to MM:SS BCD.
// Optional low-time blink indicator enabled by LOW_TIME_BLINK_EN.
module countdown_display_reader #(
    parameter int LOW_THRESH  = 10,
    parameter int SAT_SECONDS = 5999
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        sec,
    input  logic [31:0] count_in,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic        valid,
    output logic        busy,
    output logic        time_up,
    output logic        expired,
    output logic        low_time
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DIV60   = 2'd1;
    localparam logic [1:0] DIV10_M = 2'd2;
    localparam logic [1:0] DIV10_S = 2'd3;

    logic [1:0]  state;
    logic [12:0] rem;
    logic [6:0]  m;
    logic [3:0]  mt;
    logic [3:0]  st;
    logic        pending;
    logic [12:0] hold_val;
    logic        hold_zero;
    logic        cur_zero;
    logic [12:0] samp_val;
    logic        samp_zero;
    logic        start;
    logic        done;

    // Negative or zero counts display 00:00 and count as a timeout sample.
    always_comb begin
        samp_zero = count_in[31] || (count_in == 32'd0);
        if (samp_zero)
            samp_val = '0;
        else if ($signed(count_in) > SAT_SECONDS)
            samp_val = 13'(SAT_SECONDS);
        else
            samp_val = count_in[12:0];
    end

    assign start = (state == IDLE) && (sec || pending);
    assign done  = (state == DIV10_S) && (rem < 13'd10);
    assign busy  = (state != IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            rem       <= '0;
            m         <= '0;
            mt        <= '0;
            st        <= '0;
            pending   <= 1'b0;
            hold_val  <= '0;
            hold_zero <= 1'b0;
            cur_zero  <= 1'b0;
            min_tens  <= '0;
            min_ones  <= '0;
            sec_tens  <= '0;
            sec_ones  <= '0;
            valid     <= 1'b0;
            time_up   <= 1'b0;
            expired   <= 1'b0;
        end else begin
            valid   <= 1'b0;
            expired <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem      <= sec ? samp_val : hold_val;
                        cur_zero <= sec ? samp_zero : hold_zero;
                        m        <= '0;
                        mt       <= '0;
                        st       <= '0;
                        pending  <= 1'b0;
                        state    <= DIV60;
                    end
                end
                DIV60: begin
                    if (rem >= 13'd60) begin
                        rem <= rem - 13'd60;
                        m   <= m + 7'd1;
                    end else begin
                        state <= DIV10_M;
                    end
                end
                DIV10_M: begin
                    if (m >= 7'd10) begin
                        m  <= m - 7'd10;
                        mt <= mt + 4'd1;
                    end else begin
                        state <= DIV10_S;
                    end
                end
                DIV10_S: begin
                    if (!done) begin
                        rem <= rem - 13'd10;
                        st  <= st + 4'd1;
                    end else begin
                        min_tens <= mt;
                        min_ones <= m[3:0];
                        sec_tens <= st;
                        sec_ones <= rem[3:0];
                        valid    <= 1'b1;
                        time_up  <= time_up | cur_zero;
                        expired  <= cur_zero & ~time_up;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Strobes during a conversion are held; the latest one wins.
            if (sec && busy) begin
                pending   <= 1'b1;
                hold_val  <= samp_val;
                hold_zero <= samp_zero;
            end
        end
    end

`ifdef LOW_TIME_BLINK_EN
    logic samp_low;
    logic hold_low;
    logic cur_low;

    assign samp_low = !samp_zero && (samp_val <= 13'(LOW_THRESH));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hold_low <= 1'b0;
            cur_low  <= 1'b0;
            low_time <= 1'b0;
        end else begin
            if (start)
                cur_low <= sec ? samp_low : hold_low;
            if (sec && busy)
                hold_low <= samp_low;
            if (done)
                low_time <= cur_low ? ~low_time : 1'b0;
        end
    end
`else
    assign low_time = 1'b0;
`endif

endmodule
